// File: rtl/array_scan_reader.sv
// array_scan_reader: value-filtered word store swept by a wrap-around reader.
// Define ARRAY_SCAN_ASSERT_EN to compile in output-range assertions.
module array_scan_reader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int LIMIT  = 200
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  input  logic              out_ready,
  output logic              busy,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              done,
  output logic [8:0]        viol_cnt
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [DATA_W-1:0] LIM = DATA_W'(LIMIT);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    PRESENT,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] last_q;
  logic              accept;
  logic              fetch;
  logic              xfer;
  logic              over;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    fetch     = 1'b0;
    xfer      = 1'b0;
    busy      = 1'b1;
    out_valid = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          accept    = 1'b1;
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        fetch     = 1'b1;
        state_nxt = PRESENT;
      end
      PRESENT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          xfer      = 1'b1;
          state_nxt = (cur_addr == last_q) ? DONE : FETCH;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // out-of-range writes are dropped so stored words stay below LIMIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en && (wr_data < LIM)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign over = (out_data >= LIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_addr <= '0;
      last_q   <= '0;
      out_addr <= '0;
      out_data <= '0;
      viol_cnt <= '0;
    end else begin
      if (accept) begin
        cur_addr <= first_addr;
        last_q   <= last_addr;
        viol_cnt <= '0;
      end
      if (fetch) begin
        out_addr <= cur_addr;
        out_data <= mem[cur_addr];
      end
      if (xfer) begin
        if (over && (viol_cnt != 9'h1FF)) begin
          viol_cnt <= viol_cnt + 9'd1;
        end
        if (cur_addr != last_q) begin
          cur_addr <= cur_addr + ADDR_W'(1);
        end
      end
    end
  end

`ifdef ARRAY_SCAN_ASSERT_EN
  always_comb begin
    assert (!out_valid || (out_data < LIM));
    assert (viol_cnt == 9'd0);
  end
`endif

endmodule
